// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the bridge state type used by the
// FemtoRV32-to-AHB master bridge and its bench.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'b000,
        HSIZE_HALF  = 3'b001,
        HSIZE_WORD  = 3'b010,
        HSIZE_DWORD = 3'b011
    } hsize_t;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_ERR  = 2'b11
    } bridge_state_t;

endpackage

// File: rtl/ahb_wmask_decode.sv
// Turns a byte-lane mask plus the current lane counter into the HSIZE,
// lane offset and split-beat sequencing for one AHB transfer.
module ahb_wmask_decode
    import ahb_pkg::*;
#(
    parameter int STRB = 4,
    parameter int LW   = $clog2(STRB)
) (
    input  logic [STRB-1:0] mask,
    input  logic [LW-1:0]   lane,
    output logic [2:0]      size,
    output logic [LW-1:0]   lane_offset,
    output logic            split,
    output logic [LW-1:0]   next_lane,
    output logic            last
);

    logic [STRB-1:0] grp;
    logic            found;
    logic            more;
    logic [LW-1:0]   first;

    always_comb begin
        size        = HSIZE_BYTE;
        lane_offset = '0;
        split       = 1'b1;
        next_lane   = '0;
        last        = 1'b1;
        grp         = '0;
        found       = 1'b0;
        more        = 1'b0;
        first       = '0;

        // A mask is a single transfer only when it is 2^k ones aligned to 2^k.
        for (int k = 0; k <= LW; k++) begin
            grp = STRB'((64'd1 << (1 << k)) - 64'd1);
            for (int o = 0; o < STRB; o++) begin
                if (((o % (1 << k)) == 0) && (mask == (grp << o))) begin
                    split       = 1'b0;
                    size        = 3'(k);
                    lane_offset = LW'(o);
                end
            end
        end

        if (split) begin
            for (int i = 0; i < STRB; i++) begin
                if (!found && (i >= int'(lane)) && mask[i]) begin
                    found = 1'b1;
                    first = LW'(i);
                end
            end
            for (int i = 0; i < STRB; i++) begin
                if ((i > int'(first)) && mask[i]) more = 1'b1;
            end
            size        = HSIZE_BYTE;
            lane_offset = first;
            next_lane   = first + 1'b1;
            last        = !more;
        end
    end

endmodule

// File: rtl/ahb_lite_master_bridge.sv
// FemtoRV32 mem_* port to AHB-Lite master: one outstanding SINGLE transfer,
// mask-driven HSIZE/HADDR, byte splitting of irregular masks, ERROR handling.
module ahb_lite_master_bridge
    import ahb_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH/8-1:0]   mem_wmask,
    input  logic                      mem_rstrb,
    output logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      mem_rbusy,
    output logic                      mem_wbusy,
    output logic                      bus_err,
    output logic [ADDR_WIDTH-1:0]     err_addr,
    output logic [ADDR_WIDTH-1:0]     HADDR,
    output logic                      HWRITE,
    output logic [2:0]                HSIZE,
    output logic [2:0]                HBURST,
    output logic [3:0]                HPROT,
    output logic [1:0]                HTRANS,
    output logic                      HMASTLOCK,
    output logic [DATA_WIDTH-1:0]     HWDATA,
    input  logic                      HREADY,
    input  logic                      HRESP,
    input  logic [DATA_WIDTH-1:0]     HRDATA,
    output bridge_state_t             state_dbg
);

    localparam int STRB = DATA_WIDTH / 8;
    localparam int LW   = $clog2(STRB);

    // Handshake: a request is mem_rstrb or a nonzero mem_wmask for one cycle and is
    // taken only in IDLE; the matching busy stays high from that cycle until the
    // result is registered. On AHB, each phase ends on the cycle HREADY is 1.

    bridge_state_t         state_q, state_d;
    logic                  op_write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [STRB-1:0]       mask_q;
    logic [LW-1:0]         lane_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  bus_err_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;

    logic [2:0]            dec_size;
    logic [LW-1:0]         dec_offset;
    logic                  dec_split;
    logic [LW-1:0]         dec_next_lane;
    logic                  dec_last;

    logic                  accept;
    logic                  beat_ok;
    logic                  beat_err;
    logic [ADDR_WIDTH-1:0] beat_addr;

    ahb_wmask_decode #(.STRB(STRB), .LW(LW)) u_decode (
        .mask        (mask_q),
        .lane        (lane_q),
        .size        (dec_size),
        .lane_offset (dec_offset),
        .split       (dec_split),
        .next_lane   (dec_next_lane),
        .last        (dec_last)
    );

    assign accept    = (state_q == ST_IDLE) && (mem_rstrb || (mem_wmask != '0));
    assign beat_addr = {addr_q[ADDR_WIDTH-1:LW], dec_offset};

    always_comb begin
        state_d  = state_q;
        beat_ok  = 1'b0;
        beat_err = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_ADDR;
            ST_ADDR: if (HREADY) state_d = ST_DATA;
            ST_DATA: begin
                if (HREADY) begin
                    // HRESP with HREADY in one cycle is a malformed error; finish it here.
                    if (HRESP == HRESP_ERROR) begin
                        beat_err = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        beat_ok = 1'b1;
                        state_d = dec_last ? ST_IDLE : ST_ADDR;
                    end
                end else if (HRESP == HRESP_ERROR) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                if (HREADY) begin
                    beat_err = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            mask_q     <= '0;
            lane_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= beat_err;
            if (accept) begin
                op_write_q <= !mem_rstrb;
                addr_q     <= mem_addr;
                mask_q     <= mem_rstrb ? '1 : mem_wmask;
                lane_q     <= '0;
                if (!mem_rstrb) wdata_q <= mem_wdata;
            end
            if (beat_ok) begin
                if (!op_write_q) rdata_q <= HRDATA;
                if (dec_split && !dec_last) lane_q <= dec_next_lane;
            end
            if (beat_err) begin
                err_addr_q <= beat_addr;
                if (!op_write_q) rdata_q <= '0;
            end
        end
    end

    assign HTRANS    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = (state_q == ST_IDLE) ? '0 : beat_addr;
    assign HWRITE    = (state_q != ST_IDLE) && op_write_q;
    assign HSIZE     = (state_q == ST_IDLE) ? 3'b000 : dec_size;
    assign HWDATA    = wdata_q;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

    assign mem_rdata = rdata_q;
    assign mem_rbusy = mem_rstrb || ((state_q != ST_IDLE) && !op_write_q);
    assign mem_wbusy = (mem_wmask != '0) || ((state_q != ST_IDLE) && op_write_q);
    assign bus_err   = bus_err_q;
    assign err_addr  = err_addr_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ahb_lite_master_bridge.sv
// Directed bench for ahb_lite_master_bridge: bench-driven slave responses,
// hand-computed expectations and an address-phase scoreboard.
module tb_ahb_lite_master_bridge;
    import ahb_pkg::*;

    logic          HCLK;
    logic          HRESET;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wmask;
    logic          mem_rstrb;
    logic [31:0]   mem_rdata;
    logic          mem_rbusy;
    logic          mem_wbusy;
    logic          bus_err;
    logic [31:0]   err_addr;
    logic [31:0]   HADDR;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [2:0]    HBURST;
    logic [3:0]    HPROT;
    logic [1:0]    HTRANS;
    logic          HMASTLOCK;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HRESP;
    logic [31:0]   HRDATA;
    bridge_state_t state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    ahb_lite_master_bridge dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rstrb (mem_rstrb),
        .mem_rdata (mem_rdata),
        .mem_rbusy (mem_rbusy),
        .mem_wbusy (mem_wbusy),
        .bus_err   (bus_err),
        .err_addr  (err_addr),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HTRANS    (HTRANS),
        .HMASTLOCK (HMASTLOCK),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    // scoreboard: every accepted address phase must match the next expected HADDR
    always @(negedge HCLK) begin
        if (HTRANS == HTRANS_NONSEQ && HREADY) begin
            check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("beat_haddr", HADDR, exp_q.pop_front());
        end
    end

    always @(posedge HCLK) begin
        if (!HRESET)
            assert (!(mem_rstrb && (mem_wmask != 4'b0000)))
            else $error("illegal request: read and write in the same cycle");
    end

    // drivers
    task automatic read_zw(input logic [31:0] addr, input logic [31:0] haddr,
                           input logic [31:0] data);
        exp_q.push_back(haddr);
        mem_addr  = addr;
        mem_rstrb = 1'b1;
        @(negedge HCLK);
        check("rd_rbusy_c0", mem_rbusy, 1);
        check("rd_htrans_c0", HTRANS, HTRANS_IDLE);
        next_cycle();
        mem_rstrb = 1'b0;
        @(negedge HCLK);
        check("rd_htrans_c1", HTRANS, HTRANS_NONSEQ);
        check("rd_hsize_c1", HSIZE, 3'd2);
        check("rd_hwrite_c1", HWRITE, 0);
        check("rd_rbusy_c1", mem_rbusy, 1);
        next_cycle();
        HRDATA = data;
        @(negedge HCLK);
        check("rd_htrans_c2", HTRANS, HTRANS_IDLE);
        check("rd_rbusy_c2", mem_rbusy, 1);
        next_cycle();
        HRDATA = 32'h0;
        @(negedge HCLK);
        check("rd_rdata_c3", mem_rdata, data);
        check("rd_rbusy_c3", mem_rbusy, 0);
        next_cycle();
    endtask

    task automatic write_single(input logic [31:0] addr, input logic [3:0] mask,
                                input logic [31:0] wdata, input logic [31:0] haddr,
                                input logic [2:0] size);
        exp_q.push_back(haddr);
        mem_addr  = addr;
        mem_wmask = mask;
        mem_wdata = wdata;
        @(negedge HCLK);
        check("wr_wbusy_c0", mem_wbusy, 1);
        next_cycle();
        mem_wmask = 4'b0000;
        mem_wdata = 32'h0;
        @(negedge HCLK);
        check("wr_htrans_c1", HTRANS, HTRANS_NONSEQ);
        check("wr_haddr_c1", HADDR, haddr);
        check("wr_hsize_c1", HSIZE, size);
        check("wr_hwrite_c1", HWRITE, 1);
        check("wr_wbusy_c1", mem_wbusy, 1);
        next_cycle();
        @(negedge HCLK);
        check("wr_hwdata_c2", HWDATA, wdata);
        check("wr_htrans_c2", HTRANS, HTRANS_IDLE);
        check("wr_wbusy_c2", mem_wbusy, 1);
        next_cycle();
        @(negedge HCLK);
        check("wr_wbusy_c3", mem_wbusy, 0);
        check("wr_state_c3", state_dbg, ST_IDLE);
        next_cycle();
    endtask

    logic [3:0]  t_mask [5] = '{4'b1100, 4'b0001, 4'b1000, 4'b0011, 4'b1111};
    logic [31:0] t_off  [5] = '{32'd2, 32'd0, 32'd3, 32'd0, 32'd0};
    logic [2:0]  t_size [5] = '{3'd1, 3'd0, 3'd0, 3'd1, 3'd2};
    logic [1:0]  sp_tr  [4] = '{HTRANS_NONSEQ, HTRANS_IDLE, HTRANS_NONSEQ, HTRANS_IDLE};

    initial begin
        HRESET = 1'b1; mem_addr = '0; mem_wdata = '0; mem_wmask = '0; mem_rstrb = 1'b0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_htrans", HTRANS, HTRANS_IDLE);
        check("rst_haddr", HADDR, 0);
        check("rst_hwrite", HWRITE, 0);
        check("rst_hsize", HSIZE, 0);
        check("rst_hwdata", HWDATA, 0);
        check("rst_rdata", mem_rdata, 0);
        check("rst_rbusy", mem_rbusy, 0);
        check("rst_wbusy", mem_wbusy, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_err_addr", err_addr, 0);
        check("rst_state", state_dbg, ST_IDLE);
        check("const_hburst", HBURST, 3'b000);
        check("const_hprot", HPROT, 4'b0011);
        check("const_hmastlock", HMASTLOCK, 0);
        next_cycle();
        HRESET = 1'b0;
        next_cycle();

        // zero-wait read
        read_zw(32'h0000_1000, 32'h0000_1000, 32'hDEAD_BEEF);

        // single-transfer write masks
        for (int i = 0; i < 5; i++) begin
            if (i == 0)
                write_single(32'h2000, t_mask[i], 32'hAABB_0000, 32'h2000 + t_off[i], t_size[i]);
            else
                write_single(32'h7000 + 32'(i) * 32'h10, t_mask[i], 32'hA500_0000 | 32'(i),
                             32'h7000 + 32'(i) * 32'h10 + t_off[i], t_size[i]);
        end

        // split write 0101: byte beats at 0x3000 then 0x3002
        exp_q.push_back(32'h3000);
        exp_q.push_back(32'h3002);
        mem_addr = 32'h3000; mem_wmask = 4'b0101; mem_wdata = 32'h1122_3344;
        @(negedge HCLK);
        check("sp_wbusy_c0", mem_wbusy, 1);
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            mem_wmask = 4'b0000;
            @(negedge HCLK);
            check("sp_htrans", HTRANS, sp_tr[c-1]);
            check("sp_wbusy", mem_wbusy, 1);
            check("sp_hsize", HSIZE, 0);
        end
        next_cycle();
        @(negedge HCLK);
        check("sp_wbusy_end", mem_wbusy, 0);
        check("sp_htrans_end", HTRANS, HTRANS_IDLE);
        next_cycle();

        // read with three DATA wait states, unaligned CPU address
        exp_q.push_back(32'h1004);
        mem_addr = 32'h1006; mem_rstrb = 1'b1;
        next_cycle();
        mem_rstrb = 1'b0;
        @(negedge HCLK);
        check("ws_haddr_c1", HADDR, 32'h1004);
        for (int c = 2; c <= 4; c++) begin
            next_cycle();
            HREADY = 1'b0;
            @(negedge HCLK);
            check("ws_haddr_hold", HADDR, 32'h1004);
            check("ws_rbusy", mem_rbusy, 1);
            check("ws_rdata_hold", mem_rdata, 32'hDEAD_BEEF);
        end
        next_cycle();
        HREADY = 1'b1; HRDATA = 32'h1234_5678;
        @(negedge HCLK);
        check("ws_rbusy_c5", mem_rbusy, 1);
        next_cycle();
        HRDATA = 32'h0;
        @(negedge HCLK);
        check("ws_rdata_c6", mem_rdata, 32'h1234_5678);
        check("ws_rbusy_c6", mem_rbusy, 0);
        next_cycle();

        // two-cycle ERROR on a full-word write
        exp_q.push_back(32'h4000);
        mem_addr = 32'h4000; mem_wmask = 4'b1111; mem_wdata = 32'hCAFE_0001;
        next_cycle();
        mem_wmask = 4'b0000;
        next_cycle();
        HRESP = 1'b1; HREADY = 1'b0;
        @(negedge HCLK);
        check("er_bus_err_c2", bus_err, 0);
        check("er_state_c2", state_dbg, ST_DATA);
        next_cycle();
        HREADY = 1'b1;
        @(negedge HCLK);
        check("er_state_c3", state_dbg, ST_ERR);
        check("er_bus_err_c3", bus_err, 0);
        next_cycle();
        HRESP = 1'b0;
        @(negedge HCLK);
        check("er_bus_err_c4", bus_err, 1);
        check("er_err_addr", err_addr, 32'h4000);
        check("er_state_c4", state_dbg, ST_IDLE);
        check("er_wbusy_c4", mem_wbusy, 0);
        next_cycle();
        @(negedge HCLK);
        check("er_bus_err_c5", bus_err, 0);
        next_cycle();
        read_zw(32'h0000_1000, 32'h0000_1000, 32'h0BAD_F00D);

        // HRESP and HREADY together in DATA on a read
        exp_q.push_back(32'h6008);
        mem_addr = 32'h600A; mem_rstrb = 1'b1;
        next_cycle();
        mem_rstrb = 1'b0;
        next_cycle();
        HRESP = 1'b1; HRDATA = 32'h5555_5555;
        next_cycle();
        HRESP = 1'b0; HRDATA = 32'h0;
        @(negedge HCLK);
        check("pv_bus_err", bus_err, 1);
        check("pv_err_addr", err_addr, 32'h6008);
        check("pv_rdata_zero", mem_rdata, 0);
        check("pv_state", state_dbg, ST_IDLE);
        check("pv_rbusy", mem_rbusy, 0);
        next_cycle();

        // reset during DATA of a split write 1010; slave error that cycle is ignored
        exp_q.push_back(32'h5001);
        mem_addr = 32'h5000; mem_wmask = 4'b1010; mem_wdata = 32'h9988_7766;
        next_cycle();
        mem_wmask = 4'b0000;
        @(negedge HCLK);
        check("rs_haddr_c1", HADDR, 32'h5001);
        next_cycle();
        @(negedge HCLK);
        check("rs_state_c2", state_dbg, ST_DATA);
        HRESET = 1'b1; HRESP = 1'b1;
        next_cycle();
        HRESET = 1'b0; HRESP = 1'b0;
        @(negedge HCLK);
        check("rs_htrans", HTRANS, HTRANS_IDLE);
        check("rs_rbusy", mem_rbusy, 0);
        check("rs_wbusy", mem_wbusy, 0);
        check("rs_bus_err", bus_err, 0);
        check("rs_state", state_dbg, ST_IDLE);
        check("rs_err_addr", err_addr, 0);
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            @(negedge HCLK);
            check("rs_no_beat", HTRANS, HTRANS_IDLE);
            check("rs_no_err", bus_err, 0);
        end
        next_cycle();
        read_zw(32'h0000_2004, 32'h0000_2004, 32'h0F0F_1234);

        check("scoreboard_drained", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
